// File: rtl/mac_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 8x8 multiply-accumulate unit.
// The granted requester streams len operand pairs; the saturating 17-bit sum is reported with a done pulse.
//
//   state | meaning
//   IDLE  | waiting for req0/req1, arbitration happens here
//   BUSY  | winner granted, one operand pair accumulated per cycle
//   DONE  | one-cycle done pulse, result/ovf just updated
module mac_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [3:0]  len0,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic        req1,
  input  logic [3:0]  len1,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [16:0] result,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] acc_q, acc_d;
  logic        sat_q, sat_d;
  logic [16:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        gnt0_q, gnt1_q, busy_q, done_q, done_id_q;

  logic [7:0]  op_a, op_b;
  logic [15:0] prod;
  logic [17:0] sum;
  logic        sum_ovf;
  logic [16:0] acc_sat;
  logic        winner;
  logic [3:0]  win_len;

  assign op_a    = id_q ? a1 : a0;
  assign op_b    = id_q ? b1 : b0;
  assign prod    = 16'(op_a) * 16'(op_b);
  assign sum     = {1'b0, acc_q} + {2'b00, prod};
  assign sum_ovf = sum[17];
  assign acc_sat = sum_ovf ? 17'h1FFFF : sum[16:0];

  // On a tie the requester that was not served last wins.
  assign winner  = (req0 && req1) ? ~last_q : req1;
  assign win_len = winner ? len1 : len0;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    last_d   = last_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          id_d   = winner;
          last_d = winner;
          len_d  = win_len;
          cnt_d  = 4'd0;
          acc_d  = 17'd0;
          sat_d  = 1'b0;
          if (win_len == 4'd0) begin
            state_d  = DONE;
            result_d = 17'd0;
            ovf_d    = 1'b0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = acc_sat;
        sat_d = sat_q | sum_ovf;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == len_q - 4'd1) begin
          state_d  = DONE;
          result_d = acc_sat;
          ovf_d    = sat_q | sum_ovf;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      len_q     <= 4'd0;
      cnt_q     <= 4'd0;
      acc_q     <= 17'd0;
      sat_q     <= 1'b0;
      result_q  <= 17'd0;
      ovf_q     <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_q    <= last_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      gnt0_q    <= (state_d == BUSY) && !id_d;
      gnt1_q    <= (state_d == BUSY) && id_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      done_id_q <= (state_d == DONE) && id_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-low reset (rst=0 sampled at a rising edge resets the block).
REQ-003 SHALL have port: req0  input  1  requester 0 job request, level-sensitive.
REQ-004 SHALL have port: len0  input  4  requester 0 job length in operand pairs, 0..15.
REQ-005 SHALL have port: a0  input  8  requester 0 operand a, unsigned.
REQ-006 SHALL have port: b0  input  8  requester 0 operand b, unsigned.
REQ-007 SHALL have ports req1, len1, a1, b1, identical to REQ-003..006 for requester 1.
REQ-008 SHALL have port: gnt0  output  1  requester 0 owns the MAC; operand pair a0/b0 consumed at each rising edge while high.
REQ-009 SHALL have port: gnt1  output  1  same as gnt0 for requester 1.
REQ-010 SHALL have port: busy  output  1  job in progress (state BUSY or DONE).
REQ-011 SHALL have port: done  output  1  one-cycle pulse, job result valid.
REQ-012 SHALL have port: done_id  output  1  requester that owned the completed job.
REQ-013 SHALL have port: result  output  17  unsigned accumulated sum of products of the last job.
REQ-014 SHALL have port: ovf  output  1  last job saturated.

Function
REQ-015 SHALL implement FSM with states IDLE, BUSY, DONE; all outputs registered or decoded from registered state only.
REQ-016 IDLE: SHALL sample req0/req1; if none, stay in IDLE.
REQ-017 Arbitration: SHALL be round-robin; single request wins; on simultaneous requests, the requester not served last wins; the last-served pointer SHALL reset to 1, so req0 wins the first tie.
REQ-018 On grant: SHALL latch winner id and its len; clear accumulator, counter, and ovf flag internally; go to BUSY (len>0) or DONE (len=0).
REQ-019 BUSY: gnt of the winner SHALL be 1, the other 0; at each edge acc <= sat(acc + a*b) using winner operands, cnt++.
REQ-020 BUSY SHALL last exactly len cycles; at the edge where cnt = len-1, SHALL go to DONE.
REQ-021 Products SHALL be 16-bit unsigned; sums SHALL saturate at 17'h1FFFF; any saturation SHALL set the job ovf flag sticky until next grant.
REQ-022 DONE: one cycle; done=1, done_id=winner, gnt0=gnt1=0; result/ovf SHALL update on entry to DONE and hold until the next DONE.
REQ-023 DONE SHALL always go to IDLE; minimum spacing between grants = len+2 cycles.
REQ-024 len=0: SHALL produce DONE with result=0, ovf=0; gnt never asserted.
REQ-025 req/len changes during BUSY/DONE SHALL be ignored; requester dropping req mid-job SHALL NOT abort the job.
REQ-026 gnt0 and gnt1 SHALL never be high together.

Reset
REQ-027 rst=0 at an edge SHALL force IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0, result=0, ovf=0, counter=0, last-served pointer=1, from any state.
REQ-028 Reset mid-job SHALL discard the job: no done pulse; result stays 0 until a later job completes.

Verification
REQ-029 Reset: rst=0 for 2 edges with req0=req1=1 -> all outputs 0 during and 1 cycle after reset release.
REQ-030 Single job: req0=1, len0=3, pairs (4,3),(2,6),(16,2) -> gnt0 high 3 cycles, then done=1, done_id=0, result=56, ovf=0.
REQ-031 Tie and fairness: req0=req1=1 continuously, len0=len1=1 -> grants alternate 0,1,0,1; done_id follows; gnt never overlaps.
REQ-032 Zero length: req1=1, len1=0 -> DONE one cycle after grant decision, done_id=1, result=0, gnt1 never asserted.
REQ-033 Saturation: len0=3, a0=b0=255 -> result=17'h1FFFF, ovf=1; the next job with (1,1),len=1 gives result=1, ovf=0.
REQ-034 Reset mid-job: len0=5, rst=0 at the 3rd BUSY cycle -> IDLE next cycle, no done, result=0.
